jtgng_romload: RTL and testbench

- Feeds the ROM storage banks during download; it is the write-side counterpart of the ROM bank decoder.
- Accepts the byte stream from the HPS downloader and buffers it in a small FIFO.
- Drops addresses outside the ROM image and emits paced single-cycle romload_wr/romload_addr/romload_data writes.
- Provides the loading and done status that holds the game core in reset until the image is complete.

---
 rtl/jtgng_romload.sv | 190 +++++++++++++++++++
 tb/tb_jtgng_romload.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtgng_romload.sv
// ROM download write-side: buffers downloader bytes in a small FIFO and emits paced
// single-cycle ROM bank writes. Optional checksum output under JTGNG_ROMLOAD_CSUM_EN.
module jtgng_romload #(
  parameter int          FIFO_AW = 2,
  parameter int          WR_GAP  = 3,
  parameter logic [18:0] ROM_END = 19'h60000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [21:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        romload_wr,
  output logic [18:0] romload_addr,
  output logic [7:0]  romload_data,
  output logic        loading,
  output logic        done,
  output logic        overflow
`ifdef JTGNG_ROMLOAD_CSUM_EN
 ,output logic [15:0] csum
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int         DEPTH    = 1 << FIFO_AW;
  localparam logic [3:0] GAP_LOAD = 4'(WR_GAP - 1);

  state_t             state_r;
  state_t             state_s;
  logic               load_entry_s;
  logic               dl_r;
  logic               dl_rise_s;
  logic               dl_fall_s;

  logic [26:0]        mem_r [DEPTH];
  logic [FIFO_AW:0]   wr_ptr_r;
  logic [FIFO_AW:0]   rd_ptr_r;
  logic               empty_s;
  logic               full_s;
  logic               push_req_s;
  logic               push_s;
  logic               pop_s;
  logic               ovf_set_s;
  logic [3:0]         gap_r;

  // Download edge detection and FIFO handshake decode
  always_comb begin
    dl_rise_s  = ioctl_download & ~dl_r;
    dl_fall_s  = ~ioctl_download & dl_r;
    empty_s    = (wr_ptr_r == rd_ptr_r);
    full_s     = (wr_ptr_r[FIFO_AW] != rd_ptr_r[FIFO_AW]) &&
                 (wr_ptr_r[FIFO_AW-1:0] == rd_ptr_r[FIFO_AW-1:0]);
    push_req_s = (state_r == ST_LOAD) && ioctl_wr && (ioctl_addr < {3'b000, ROM_END});
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    pop_s      = !empty_s && (gap_r == 4'd0) && !romload_wr;
    push_s     = push_req_s && (!full_s || pop_s);
    ovf_set_s  = push_req_s && full_s && !pop_s;
  end

  // Next-state logic
  always_comb begin
    state_s      = state_r;
    load_entry_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (dl_rise_s) begin
          state_s      = ST_LOAD;
          load_entry_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (dl_fall_s) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_DRAIN: begin
        if (empty_s && (gap_r == 4'd0)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (dl_rise_s) begin
          state_s      = ST_LOAD;
          load_entry_s = 1'b1;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register and registered download level
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      dl_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      dl_r    <= ioctl_download;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[FIFO_AW-1:0]] <= {ioctl_addr[18:0], ioctl_dout};
    end
  end

  // FIFO pointers, wrapping modulo 2**(FIFO_AW+1)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
    end
  end

  // Write strobe, held address/data and gap counter
  always_ff @(posedge clk) begin
    if (rst) begin
      romload_wr   <= 1'b0;
      romload_addr <= 19'd0;
      romload_data <= 8'd0;
      gap_r        <= 4'd0;
    end else begin
      romload_wr <= pop_s;
      if (pop_s) begin
        {romload_addr, romload_data} <= mem_r[rd_ptr_r[FIFO_AW-1:0]];
        // Loaded together with the strobe so pulses land exactly WR_GAP cycles apart.
        gap_r <= GAP_LOAD;
      end else if (gap_r != 4'd0) begin
        gap_r <= gap_r - 4'd1;
      end
    end
  end

  // Status outputs registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      loading  <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      loading <= (state_s == ST_LOAD) || (state_s == ST_DRAIN);
      done    <= (state_s == ST_DONE);
      if (load_entry_s) begin
        overflow <= 1'b0;
      end else if (ovf_set_s) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef JTGNG_ROMLOAD_CSUM_EN
  // Running modular sum of written bytes since the last LOAD entry
  always_ff @(posedge clk) begin
    if (rst) begin
      csum <= 16'd0;
    end else if (load_entry_s) begin
      csum <= 16'd0;
    end else if (romload_wr) begin
      csum <= csum + {8'h00, romload_data};
    end
  end
`endif

endmodule

// File: tb/tb_jtgng_romload.sv
// Directed self-checking bench for jtgng_romload (default parameters).
module tb_jtgng_romload;

  logic        clk = 1'b0;
  logic        rst;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [21:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        romload_wr;
  logic [18:0] romload_addr;
  logic [7:0]  romload_data;
  logic        loading;
  logic        done;
  logic        overflow;
`ifdef JTGNG_ROMLOAD_CSUM_EN
  logic [15:0] csum;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [18:0] q_addr [$];
  logic [7:0]  q_data [$];
  int          q_cyc  [$];

  jtgng_romload #(
    .FIFO_AW (2),
    .WR_GAP  (3),
    .ROM_END (19'h60000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .romload_wr     (romload_wr),
    .romload_addr   (romload_addr),
    .romload_data   (romload_data),
    .loading        (loading),
    .done           (done),
    .overflow       (overflow)
`ifdef JTGNG_ROMLOAD_CSUM_EN
   ,.csum           (csum)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every write pulse with the cycle it appeared in
  always @(negedge clk) begin
    if (romload_wr === 1'b1) begin
      q_addr.push_back(romload_addr);
      q_data.push_back(romload_data);
      q_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [21:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    step();
    ioctl_wr   = 1'b0;
  endtask

  task automatic clear_log();
    q_addr.delete();
    q_data.delete();
    q_cyc.delete();
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (done === 1'b1) break;
      step();
    end
    chk(tag, done, 1);
  endtask

  logic [18:0] exp_addr [7];
  int          done_cyc;
  logic        load_ok;

  initial begin
    rst = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = 22'd0; ioctl_dout = 8'd0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("init_wr", romload_wr, 0);
    chk("init_loading", loading, 0);
    chk("init_done", done, 0);
    chk("init_overflow", overflow, 0);
    chk("init_addr", romload_addr, 0);
    chk("init_data", romload_data, 0);

    // Single byte, two-cycle latency
    ioctl_download = 1'b1;
    step();
    chk("t1_loading", loading, 1);
    chk("t1_done", done, 0);
    step();
    clear_log();
    put(22'h00014, 8'hA5);
    chk("t1_wr_n1", romload_wr, 0);
    step();
    chk("t1_wr_n2", romload_wr, 1);
    chk("t1_addr", romload_addr, 19'h00014);
    chk("t1_data", romload_data, 8'hA5);
    step();
    chk("t1_wr_low", romload_wr, 0);
    chk("t1_addr_hold", romload_addr, 19'h00014);
    chk("t1_data_hold", romload_data, 8'hA5);
    ioctl_download = 1'b0;
    step();
    wait_done("t1_done_set");
    chk("t1_loading_off", loading, 0);
    chk("t1_count", q_addr.size(), 1);
`ifdef JTGNG_ROMLOAD_CSUM_EN
    chk("t1_csum", csum, 16'h00A5);
`endif

    // Out-of-range addresses are silently dropped
    ioctl_download = 1'b1;
    step();
    chk("t2_done_clr", done, 0);
    chk("t2_loading", loading, 1);
    clear_log();
    put(22'h060000, 8'h11);
    put(22'h07FFFF, 8'h22);
    put(22'h080000, 8'h44);
    repeat (6) step();
    chk("t2_oor_none", q_addr.size(), 0);
    chk("t2_oor_ovf", overflow, 0);
    put(22'h05FFFF, 8'h33);
    repeat (4) step();
    chk("t2_edge_count", q_addr.size(), 1);
    if (q_addr.size() == 1) begin
      chk("t2_edge_addr", q_addr[0], 19'h5FFFF);
      chk("t2_edge_data", q_data[0], 8'h33);
    end

    // Burst of 8 into a depth-4 FIFO: byte 6 is lost, pop frees slot for byte 7
    clear_log();
    for (int i = 0; i < 8; i++) put(22'(i), 8'(i));
    repeat (30) step();
    chk("t3_overflow", overflow, 1);
    chk("t3_count", q_addr.size(), 7);
    exp_addr = '{19'd0, 19'd1, 19'd2, 19'd3, 19'd4, 19'd5, 19'd7};
    if (q_addr.size() == 7) begin
      for (int i = 0; i < 7; i++) begin
        chk($sformatf("t3_addr%0d", i), q_addr[i], exp_addr[i]);
        chk($sformatf("t3_data%0d", i), q_data[i], 8'(exp_addr[i]));
        if (i > 0) chk($sformatf("t3_gap%0d", i), q_cyc[i] - q_cyc[i-1], 3);
      end
    end
    ioctl_download = 1'b0;
    step();
    wait_done("t3_done_set");

    // Steady rate: 256 bytes spaced 4 cycles
    ioctl_download = 1'b1;
    step();
    chk("t4_ovf_clr", overflow, 0);
    clear_log();
    for (int i = 0; i < 256; i++) begin
      put(22'(i), 8'(i) ^ 8'h5A);
      repeat (3) step();
    end
    repeat (6) step();
    chk("t4_count", q_addr.size(), 256);
    chk("t4_overflow", overflow, 0);
    if (q_addr.size() == 256) begin
      for (int i = 0; i < 256; i++) begin
        chk($sformatf("t4_addr%0d", i), q_addr[i], 19'(i));
        chk($sformatf("t4_data%0d", i), q_data[i], 8'(i) ^ 8'h5A);
      end
    end
    ioctl_download = 1'b0;
    step();
    wait_done("t4_done_set");
`ifdef JTGNG_ROMLOAD_CSUM_EN
    chk("t4_csum", csum, 16'h7F80);
`endif

    // Drain with 3 bytes queued, last byte coincides with download falling
    ioctl_download = 1'b1;
    step();
    chk("t5_restart_done", done, 0);
    chk("t5_restart_loading", loading, 1);
`ifdef JTGNG_ROMLOAD_CSUM_EN
    chk("t5_csum_clr", csum, 16'h0000);
`endif
    clear_log();
    put(22'h000100, 8'hFF);
    put(22'h000101, 8'hFF);
    ioctl_download = 1'b0;
    put(22'h000102, 8'h02);
    load_ok  = 1'b1;
    done_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      if (loading !== 1'b1) load_ok = 1'b0;
      step();
    end
    chk("t5_loading_held", load_ok, 1);
    chk("t5_done_set", done, 1);
    chk("t5_loading_off", loading, 0);
    chk("t5_count", q_addr.size(), 3);
    if (q_addr.size() == 3) begin
      chk("t5_data0", q_data[0], 8'hFF);
      chk("t5_data1", q_data[1], 8'hFF);
      chk("t5_data2", q_data[2], 8'h02);
      chk("t5_addr2", q_addr[2], 19'h00102);
      chk("t5_done_lat", done_cyc - q_cyc[2], 3);
    end
`ifdef JTGNG_ROMLOAD_CSUM_EN
    chk("t5_csum", csum, 16'h0200);
`endif

    // Reset mid-LOAD with two bytes still queued
    ioctl_download = 1'b1;
    step();
    chk("t6_loading", loading, 1);
    put(22'h000200, 8'hC3);
    put(22'h000201, 8'hC4);
    put(22'h000202, 8'hC5);
    rst = 1'b1;
    step();
    clear_log();
    chk("t6_rst_wr", romload_wr, 0);
    chk("t6_rst_loading", loading, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_overflow", overflow, 0);
    chk("t6_rst_addr", romload_addr, 0);
    repeat (2) step();
    rst = 1'b0;
    repeat (12) step();
    chk("t6_no_stale", q_addr.size(), 0);
    ioctl_download = 1'b0;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
